// File: rtl/btb_ctrl.sv
// Branch-target-buffer controller: drives both ports of the BTB RAM, sweeps it clean after reset,
// serves fetch lookups on port A and read-modify-write counter updates on port B.
module btb_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 56,
  parameter int BYTE_EN    = 7
) (
  input  logic                  clka,
  input  logic                  rstb,
  input  logic                  lookup_valid,
  input  logic [31:0]           lookup_pc,
  output logic                  lookup_ready,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic                  resp_taken,
  output logic [31:0]           resp_target,
  input  logic                  upd_valid,
  input  logic [31:0]           upd_pc,
  input  logic                  upd_taken,
  input  logic [31:0]           upd_target,
  output logic                  upd_ready,
  output logic                  init_done,
  output logic                  mem_ena,
  output logic [BYTE_EN-1:0]    mem_wea,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0] mem_dina,
  input  logic [DATA_WIDTH-1:0] mem_douta,
  output logic [BYTE_EN-1:0]    mem_web,
  output logic [ADDR_WIDTH-1:0] mem_addrb,
  output logic [DATA_WIDTH-1:0] mem_dinb,
  input  logic [DATA_WIDTH-1:0] mem_doutb,
  output logic [1:0]            dbg_state
);

  // Handshakes: a lookup transfers on a clka edge where lookup_valid && lookup_ready,
  // an update where upd_valid && upd_ready; resp_valid pulses exactly one cycle later per lookup.

  localparam int TAG_W = 30 - ADDR_WIDTH;
  localparam int V_BIT = DATA_WIDTH - 1;
  localparam int TAG_HI = DATA_WIDTH - 2;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPD_WR = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] sweep_idx;
  logic [29:0]           upd_pc_q;
  logic [29:0]           upd_tgt_q;
  logic                  upd_taken_q;
  logic                  resp_valid_q;
  logic [TAG_W-1:0]      resp_tag_q;
  logic                  byp_q;
  logic [DATA_WIDTH-1:0] byp_entry_q;

  logic                  ready_int;
  logic                  lookup_accept;
  logic                  upd_accept;
  logic                  old_hit;
  logic                  wr_en;
  logic [1:0]            old_ctr;
  logic [1:0]            new_ctr;
  logic [29:0]           new_tgt;
  logic [DATA_WIDTH-1:0] new_entry;
  logic [DATA_WIDTH-1:0] resp_entry;
  logic                  resp_match;
  logic                  unused_bits;

  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign ready_int     = (state != ST_INIT);
  assign lookup_accept = lookup_valid && ready_int;
  assign upd_accept    = upd_valid && (state == ST_IDLE);

  always_ff @(posedge clka) begin
    if (rstb) begin
      state        <= ST_INIT;
      sweep_idx    <= '0;
      upd_pc_q     <= '0;
      upd_tgt_q    <= '0;
      upd_taken_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      byp_q        <= 1'b0;
      byp_entry_q  <= '0;
    end else begin
      state        <= state_nxt;
      resp_valid_q <= lookup_accept;
      if (state == ST_INIT) sweep_idx <= sweep_idx + ADDR_WIDTH'(1);
      if (upd_accept) begin
        upd_pc_q    <= upd_pc[31:2];
        upd_tgt_q   <= upd_target[31:2];
        upd_taken_q <= upd_taken;
      end
      if (lookup_accept) begin
        resp_tag_q  <= lookup_pc[31:ADDR_WIDTH+2];
        // The RAM reads the old entry when port B writes the same index this edge.
        byp_q       <= wr_en && (lookup_pc[ADDR_WIDTH+1:2] == upd_pc_q[ADDR_WIDTH-1:0]);
        byp_entry_q <= new_entry;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:   if (sweep_idx == '1) state_nxt = ST_IDLE;
      ST_IDLE:   if (upd_valid) state_nxt = ST_UPD_WR;
      ST_UPD_WR: state_nxt = ST_IDLE;
      default:   state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    old_ctr = mem_doutb[1:0];
    old_hit = mem_doutb[V_BIT] && (mem_doutb[TAG_HI -: TAG_W] == upd_pc_q[29:ADDR_WIDTH]);
    new_ctr = 2'b10;
    new_tgt = upd_tgt_q;
    if (old_hit) begin
      if (upd_taken_q) new_ctr = (old_ctr == 2'b11) ? 2'b11 : old_ctr + 2'd1;
      else             new_ctr = (old_ctr == 2'b00) ? 2'b00 : old_ctr - 2'd1;
      if (!upd_taken_q) new_tgt = mem_doutb[31:2];
    end
    new_entry = {1'b1, upd_pc_q[29:ADDR_WIDTH], new_tgt, new_ctr};
    wr_en     = (state == ST_UPD_WR) && (old_hit || upd_taken_q);
  end

  always_comb begin
    mem_ena   = 1'b0;
    mem_wea   = '0;
    mem_addra = '0;
    mem_dina  = '0;
    mem_web   = '0;
    mem_addrb = '0;
    mem_dinb  = '0;
    if (!rstb) begin
      if (state == ST_INIT) begin
        mem_ena   = 1'b1;
        mem_wea   = '1;
        mem_addra = sweep_idx;
      end else if (lookup_accept) begin
        mem_ena   = 1'b1;
        mem_addra = lookup_pc[ADDR_WIDTH+1:2];
      end
      if (upd_accept) begin
        mem_ena   = 1'b1;
        mem_addrb = upd_pc[ADDR_WIDTH+1:2];
      end else if (wr_en) begin
        mem_ena   = 1'b1;
        mem_web   = '1;
        mem_addrb = upd_pc_q[ADDR_WIDTH-1:0];
        mem_dinb  = new_entry;
      end
    end
  end

  assign resp_entry = byp_q ? byp_entry_q : mem_douta;
  assign resp_match = resp_valid_q && !rstb && resp_entry[V_BIT]
                      && (resp_entry[TAG_HI -: TAG_W] == resp_tag_q);

  assign resp_valid   = resp_valid_q && !rstb;
  assign resp_hit     = resp_match;
  assign resp_taken   = resp_match && resp_entry[1];
  assign resp_target  = resp_match ? {resp_entry[31:2], 2'b00} : 32'd0;
  assign lookup_ready = ready_int && !rstb;
  assign init_done    = ready_int && !rstb;
  assign upd_ready    = (state == ST_IDLE) && !rstb;
  assign dbg_state    = state;

endmodule

// File: tb/tb_btb_ctrl.sv
// Bench for btb_ctrl: behavioural dual-port RAM, directed scenarios, then random traffic
// checked against an entry-level BTB model and an expected-response queue.
module tb_btb_ctrl;

  logic        clka = 1'b0;
  logic        rstb;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        lookup_ready;
  logic        resp_valid, resp_hit, resp_taken;
  logic [31:0] resp_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_ready, init_done;
  logic        mem_ena;
  logic [6:0]  mem_wea, mem_web;
  logic [6:0]  mem_addra, mem_addrb;
  logic [55:0] mem_dina, mem_dinb;
  logic [55:0] mem_douta, mem_doutb;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  logic preload;

  // clock/reset
  always #5 clka = ~clka;

  btb_ctrl dut (
    .clka(clka), .rstb(rstb),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_ready(lookup_ready),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_taken(resp_taken), .resp_target(resp_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_ready(upd_ready), .init_done(init_done),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
    .mem_douta(mem_douta), .mem_web(mem_web), .mem_addrb(mem_addrb), .mem_dinb(mem_dinb),
    .mem_doutb(mem_doutb), .dbg_state(dbg_state)
  );

  // Dual-port RAM: read-first, port A output holds on its own write cycles.
  logic [55:0] ram [128];
  always @(posedge clka) begin
    if (preload) begin
      for (int k = 0; k < 128; k++) ram[k] <= 56'({$urandom(), $urandom()}) | 56'h80_0000_0000_0000;
    end else if (mem_ena) begin
      for (int b = 0; b < 7; b++) begin
        if (mem_wea[b]) ram[mem_addra][b*8 +: 8] <= mem_dina[b*8 +: 8];
        if (mem_web[b]) ram[mem_addrb][b*8 +: 8] <= mem_dinb[b*8 +: 8];
      end
      if (mem_wea == 7'h0) mem_douta <= ram[mem_addra];
      mem_doutb <= ram[mem_addrb];
    end
  end

  // Reference model: one record per BTB index.
  bit          m_valid [128];
  logic [22:0] m_tag   [128];
  logic [31:0] m_tgt   [128];
  int          m_ctr   [128];
  logic [33:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] mk(input logic [22:0] tag, input logic [31:0] tgt, input logic [1:0] c);
    return {1'b1, tag, tgt[31:2], c};
  endfunction

  function automatic logic [33:0] predict(input logic [31:0] pc);
    int i = int'(pc[8:2]);
    if (m_valid[i] && m_tag[i] == pc[31:9]) return {1'b1, m_ctr[i] >= 2, m_tgt[i]};
    return 34'd0;
  endfunction

  task automatic model_update(input logic [31:0] pc, input logic tk, input logic [31:0] tg, output logic wr);
    int i = int'(pc[8:2]);
    if (m_valid[i] && m_tag[i] == pc[31:9]) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = {tg[31:2], 2'b00};
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
      wr = 1'b1;
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = pc[31:9];
      m_tgt[i]   = {tg[31:2], 2'b00};
      m_ctr[i]   = 2;
      wr = 1'b1;
    end else begin
      wr = 1'b0;
    end
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] p = 32'd0;
    p[10:9] = 2'($urandom_range(0, 3));
    p[3:2]  = 2'($urandom_range(0, 3));
    p[1:0]  = 2'($urandom_range(0, 3));
    return p;
  endfunction

  // driver tasks
  task automatic sweep_check();
    int nz = 0;
    for (int k = 0; k < 128; k++) begin
      #1;
      chk("sweep_ctl", {mem_ena, mem_wea, mem_addra, init_done, lookup_ready, upd_ready, mem_web},
          {1'b1, 7'h7F, 7'(k), 3'b000, 7'h00});
      chk("sweep_din", mem_dina, 56'd0);
      @(negedge clka);
    end
    #1;
    chk("sweep_done", {init_done, lookup_ready, upd_ready, mem_ena}, 4'b1110);
    for (int k = 0; k < 128; k++) if (ram[k] !== 56'd0) nz++;
    chk("sweep_ram_zero", nz, 0);
  endtask

  task automatic lookup(input logic [31:0] pc, input logic eh, input logic et, input logic [31:0] etgt);
    lookup_valid = 1'b1;
    lookup_pc = pc;
    #1;
    chk("lk_req", {mem_ena, mem_wea, mem_addra}, {1'b1, 7'h00, pc[8:2]});
    @(negedge clka);
    lookup_valid = 1'b0;
    #1;
    chk("lk_resp", {resp_valid, resp_hit, resp_taken, resp_target}, {1'b1, eh, et, etgt});
  endtask

  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                           input logic [6:0] exp_web, input logic [55:0] exp_din,
                           input logic with_lk, input logic [31:0] lk_pc);
    upd_valid = 1'b1;
    upd_pc = pc;
    upd_taken = tk;
    upd_target = tg;
    #1;
    chk("upd_rd", {upd_ready, mem_ena, mem_web, mem_addrb}, {2'b11, 7'h00, pc[8:2]});
    @(negedge clka);
    upd_valid = 1'b0;
    if (with_lk) begin
      lookup_valid = 1'b1;
      lookup_pc = lk_pc;
    end
    #1;
    chk("upd_wr_ctl", {upd_ready, mem_ena, mem_web, mem_addrb},
        {1'b0, (exp_web != 7'h0) || with_lk, exp_web, (exp_web != 7'h0) ? pc[8:2] : 7'h00});
    chk("upd_wr_din", mem_dinb, exp_din);
    @(negedge clka);
    lookup_valid = 1'b0;
    #1;
  endtask

  initial begin
    logic        busy, pend, lk_prev, exp_wr;
    logic [31:0] pu_pc, pu_tgt;
    logic        pu_taken;
    logic [33:0] ex;

    rstb = 1'b1; preload = 1'b1;
    lookup_valid = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    @(negedge clka);
    preload = 1'b0;
    @(negedge clka);
    #1;
    chk("rst_outs", {mem_ena, mem_wea, mem_web, init_done, lookup_ready, upd_ready, resp_valid},
        {1'b0, 7'h00, 7'h00, 4'b0000});

    // Sweep over junk, then a cold lookup misses.
    rstb = 1'b0;
    sweep_check();
    lookup(32'h0000_1000, 1'b0, 1'b0, 32'd0);
    @(negedge clka);
    #1;
    chk("resp_pulse", resp_valid, 1'b0);

    // Allocate, then saturate up and down.
    do_update(32'h0000_0404, 1'b1, 32'h0000_2000, 7'h7F, mk(23'd2, 32'h2000, 2'b10), 1'b0, 32'd0);
    lookup(32'h0000_0404, 1'b1, 1'b1, 32'h0000_2000);
    for (int n = 0; n < 3; n++)
      do_update(32'h0000_0404, 1'b1, 32'h0000_2000, 7'h7F, mk(23'd2, 32'h2000, 2'b11), 1'b0, 32'd0);
    do_update(32'h0000_0404, 1'b0, 32'h0000_3000, 7'h7F, mk(23'd2, 32'h2000, 2'b10), 1'b0, 32'd0);
    lookup(32'h0000_0404, 1'b1, 1'b1, 32'h0000_2000);
    do_update(32'h0000_0404, 1'b0, 32'h0000_3000, 7'h7F, mk(23'd2, 32'h2000, 2'b01), 1'b0, 32'd0);
    lookup(32'h0000_0404, 1'b1, 1'b0, 32'h0000_2000);
    do_update(32'h0000_0404, 1'b0, 32'h0000_3000, 7'h7F, mk(23'd2, 32'h2000, 2'b00), 1'b0, 32'd0);
    do_update(32'h0000_0404, 1'b0, 32'h0000_3000, 7'h7F, mk(23'd2, 32'h2000, 2'b00), 1'b0, 32'd0);
    lookup(32'h0000_0404, 1'b1, 1'b0, 32'h0000_2000);

    // Tag alias on the same index.
    lookup(32'h0000_0604, 1'b0, 1'b0, 32'd0);
    do_update(32'h0000_0604, 1'b0, 32'h0000_5000, 7'h00, 56'd0, 1'b0, 32'd0);
    lookup(32'h0000_0404, 1'b1, 1'b0, 32'h0000_2000);

    // Lookup collides with the allocating write.
    do_update(32'h0000_0808, 1'b1, 32'h0000_4440, 7'h7F, mk(23'd4, 32'h4440, 2'b10), 1'b1, 32'h0000_0808);
    chk("bypass_resp", {resp_valid, resp_hit, resp_taken, resp_target}, {3'b111, 32'h0000_4440});

    // Reset lands during the write cycle.
    upd_valid = 1'b1; upd_pc = 32'h0000_0404; upd_taken = 1'b1; upd_target = 32'h0000_6000;
    @(negedge clka);
    upd_valid = 1'b0;
    rstb = 1'b1;
    #1;
    chk("rst_mid_upd", {mem_ena, mem_web, upd_ready}, 9'd0);
    @(negedge clka);
    rstb = 1'b0;
    sweep_check();
    lookup(32'h0000_0404, 1'b0, 1'b0, 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 128; k++) m_valid[k] = 1'b0;
    pend = 1'b0; lk_prev = 1'b0; pu_pc = '0; pu_tgt = '0; pu_taken = 1'b0;
    @(negedge clka);
    for (int c = 0; c < 600; c++) begin
      busy = pend;
      exp_wr = 1'b0;
      if (pend) begin
        model_update(pu_pc, pu_taken, pu_tgt, exp_wr);
        pend = 1'b0;
      end
      lookup_valid = ($urandom_range(0, 1) == 1);
      lookup_pc = rnd_pc();
      if (lookup_valid) exp_q.push_back(predict(lookup_pc));
      upd_valid = ($urandom_range(0, 2) == 0);
      upd_pc = rnd_pc();
      upd_taken = 1'($urandom_range(0, 1));
      upd_target = $urandom();
      if (upd_valid && !busy) begin
        pend = 1'b1; pu_pc = upd_pc; pu_taken = upd_taken; pu_tgt = upd_target;
      end
      #1;
      chk("rnd_upd_ready", upd_ready, !busy);
      if (busy) chk("rnd_web", mem_web, exp_wr ? 7'h7F : 7'h00);
      chk("rnd_resp_valid", resp_valid, lk_prev);
      if (lk_prev && exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        chk("rnd_resp", {resp_hit, resp_taken, resp_target}, ex);
      end
      lk_prev = lookup_valid;
      @(negedge clka);
    end
    lookup_valid = 1'b0;
    upd_valid = 1'b0;
    #1;
    chk("rnd_last_valid", resp_valid, lk_prev);
    if (lk_prev && exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      chk("rnd_last_resp", {resp_hit, resp_taken, resp_target}, ex);
    end
    chk("rnd_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
